bus_datapath_gen2: RTL and testbench
====================================

Name: bus_datapath_gen2

Overview:
Parametrised successor to the single-bus CPU datapath. It contains:
- a register file with configurable count and width
- PC, IR, Y, Z_hi/Z_lo, HI, LO and MDR, all sharing one internal bus
- a full single-cycle ALU
- a multi-cycle unsigned multiply/divide unit with a busy/done handshake

It sits under the control unit, which drives all in/out strobes one step per clock.

Parameters:
DATA_W, 32, width of bus and all registers (8..64)
NUM_REGS, 16, number of general registers (2..32)
SHAMT_W, $clog2(DATA_W), bus bits used as shift amount

Ports:
clk  in  1  clock, rising edge
clr  in  1  reset
reg_in  in  NUM_REGS  per-register load enables (bit i -> Ri)
reg_out  in  NUM_REGS  per-register bus drive enables
pc_in, ir_in, y_in, z_in, hi_in, lo_in, mdr_in  in  1 each  load enables
pc_out, hi_out, lo_out, zhigh_out, zlow_out, mdr_out, inport_out  in  1 each  bus drive enables
inc_pc  in  1  PC increment
mdr_read  in  1  MDR source select: 1 = mdatain, 0 = bus
alu_op  in  4  ALU operation code
alu_start  in  1  start MUL/DIV
mdatain  in  DATA_W  memory read data
inport_data  in  DATA_W  input port data
bus  out  DATA_W  current bus value (observation)
ir_q  out  DATA_W  IR contents
bus_conflict  out  1  more than one driver this cycle
alu_busy  out  1  MUL/DIV in progress
alu_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: one clock; clr is synchronous and active-high. At an edge with clr=1, all registers, MDR, Z, HI, LO, PC, IR, Y and the mul/div state go to 0. alu_busy=0 and alu_done=0. clr overrides every other input on that edge.
- Bus (combinational): drivers are reg_out bits, pc_out, hi_out, lo_out, zhigh_out, zlow_out, mdr_out and inport_out.
  - Exactly one driver asserted: bus = that source.
  - Zero drivers: bus = 0, bus_conflict = 0.
  - Two or more drivers: bus = 0, bus_conflict = 1.
- Load enables: every enabled register captures bus at the rising edge. Multiple loads in the same cycle are legal.
- PC update:
  - pc_in=1: PC <= bus. pc_in wins over inc_pc.
  - Otherwise, inc_pc=1: PC <= PC+1, wrapping modulo 2^DATA_W.
- MDR: when mdr_in=1, MDR <= (mdr_read ? mdatain : bus).
- Single-cycle ALU: operands A=Y, B=bus. The result is written on an edge with z_in=1 and alu_busy=0.
  - 0 AND; 1 OR; 2 ADD; 3 SUB (A-B); 4 SHL A by B[SHAMT_W-1:0]; 5 SHR logical; 6 SHRA arithmetic; 7 NOT B; 8 NEG B (two's complement).
  - Z_lo = result.
  - Z_hi = {0.., carry-out} for ADD, {0.., borrow} for SUB, 0 otherwise.
  - Codes 11-15: Z_hi = Z_lo = 0.
- Multi-cycle unit (9 MUL, 10 DIV, both unsigned):
  - Start condition: edge with alu_start=1, alu_busy=0 and alu_op in {9,10}. This latches A=Y, B=bus and op.
  - alu_busy is high for exactly DATA_W cycles after the start edge.
  - MUL uses shift-add, one bit per cycle. DIV uses restoring division, one bit per cycle.
  - On the edge ending the last busy cycle: MUL writes Z_hi:Z_lo = 2*DATA_W product. DIV writes Z_lo = quotient, Z_hi = remainder.
  - alu_done is 1 for the following single cycle; alu_busy = 0 in that cycle.
  - Back-to-back: a new start is accepted in the done cycle.
- Divide by zero: full latency still applies. Result is Z_lo = all ones, Z_hi = dividend.
- While alu_busy=1:
  - alu_start is ignored.
  - z_in is ignored, so Z is owned by the mul/div unit.
  - Other bus transfers and loads proceed normally.
- Ignored starts: alu_start with alu_op not in {9,10} is ignored. z_in with op 9/10 writes Z_hi = Z_lo = 0.
- clr mid-operation aborts the operation: busy=0, done=0, and no Z write occurs.

Optional Feature:
Macro DP_R0_ZERO_EN.
- Defined: R0 is hardwired to zero. Writes to R0 are discarded. reg_out[0] still counts as a driver, so conflict detection is unchanged, but it drives 0.
- Undefined: R0 is an ordinary register.

Test Plan:
- Reset, then mdr_read=1, mdatain=0x12, mdr_in; then mdr_out+reg_in[3] -> R3=0x12, bus=0x12, bus_conflict=0.
- Y=0xFFFFFFFF, bus=1 (R2), alu_op=2, z_in -> Z_lo=0, Z_hi=1. Repeat with op 6, Y=0x80000000, B=4 -> Z_lo=0xF8000000.
- Y=7, bus=6, alu_op=9, alu_start -> alu_busy high for 32 cycles, done pulse, Z_hi=0, Z_lo=42. z_in with op 0 during busy leaves Z unchanged.
- DIV Y=100, B=7 -> Z_lo=14, Z_hi=2 after 32 busy cycles. DIV Y=5, B=0 -> Z_lo=0xFFFFFFFF, Z_hi=5.
- reg_out[1] and pc_out together -> bus=0, bus_conflict=1. pc_in+inc_pc with bus=0x40 -> PC=0x40. inc_pc alone at PC=0xFFFFFFFF -> PC=0.
- clr asserted at busy cycle 10 of a MUL -> next cycle busy=0, done never pulses, Z=0. With DP_R0_ZERO_EN, load R0 from bus 0x55 then reg_out[0] -> bus=0.

Source files
------------

// File: rtl/bus_datapath_gen2.sv
// rtl/bus_datapath_gen2.sv - single-bus CPU datapath with register file, ALU and multi-cycle mul/div
// Optional feature macro: DP_R0_ZERO_EN (R0 hardwired to zero)
module bus_datapath_gen2 #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int SHAMT_W  = $clog2(DATA_W)
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [NUM_REGS-1:0] reg_in,
    input  logic [NUM_REGS-1:0] reg_out,
    input  logic                pc_in,
    input  logic                ir_in,
    input  logic                y_in,
    input  logic                z_in,
    input  logic                hi_in,
    input  logic                lo_in,
    input  logic                mdr_in,
    input  logic                pc_out,
    input  logic                hi_out,
    input  logic                lo_out,
    input  logic                zhigh_out,
    input  logic                zlow_out,
    input  logic                mdr_out,
    input  logic                inport_out,
    input  logic                inc_pc,
    input  logic                mdr_read,
    input  logic [3:0]          alu_op,
    input  logic                alu_start,
    input  logic [DATA_W-1:0]   mdatain,
    input  logic [DATA_W-1:0]   inport_data,
    output logic [DATA_W-1:0]   bus,
    output logic [DATA_W-1:0]   ir_q,
    output logic                bus_conflict,
    output logic                alu_busy,
    output logic                alu_done
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_DIV = 4'd10;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] pc, ir, y, z_hi, z_lo, hi, lo, mdr;
    logic [DATA_W-1:0] md_hi, md_lo, md_b;
    logic              md_div;
    logic [CNT_W-1:0]  md_cnt;

    // Bus: OR of all enabled sources is only meaningful when exactly one drives.
    logic [5:0]        drv_cnt;
    logic [DATA_W-1:0] drv_or;

    always_comb begin
        drv_cnt = '0;
        drv_or  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_out[i]) begin
                drv_cnt = drv_cnt + 6'd1;
                drv_or  = drv_or | regs[i];
            end
        end
        if (pc_out)     begin drv_cnt = drv_cnt + 6'd1; drv_or = drv_or | pc;          end
        if (hi_out)     begin drv_cnt = drv_cnt + 6'd1; drv_or = drv_or | hi;          end
        if (lo_out)     begin drv_cnt = drv_cnt + 6'd1; drv_or = drv_or | lo;          end
        if (zhigh_out)  begin drv_cnt = drv_cnt + 6'd1; drv_or = drv_or | z_hi;        end
        if (zlow_out)   begin drv_cnt = drv_cnt + 6'd1; drv_or = drv_or | z_lo;        end
        if (mdr_out)    begin drv_cnt = drv_cnt + 6'd1; drv_or = drv_or | mdr;         end
        if (inport_out) begin drv_cnt = drv_cnt + 6'd1; drv_or = drv_or | inport_data; end
    end

    assign bus          = (drv_cnt == 6'd1) ? drv_or : '0;
    assign bus_conflict = (drv_cnt > 6'd1);
    assign ir_q         = ir;

    logic [DATA_W:0]    add_w, sub_w;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  alu_lo, alu_hi;

    assign add_w = {1'b0, y} + {1'b0, bus};
    assign sub_w = {1'b0, y} - {1'b0, bus};
    assign shamt = bus[SHAMT_W-1:0];

    always_comb begin
        alu_hi = '0;
        alu_lo = '0;
        case (alu_op)
            4'd0: alu_lo = y & bus;
            4'd1: alu_lo = y | bus;
            4'd2: begin alu_lo = add_w[DATA_W-1:0]; alu_hi[0] = add_w[DATA_W]; end
            4'd3: begin alu_lo = sub_w[DATA_W-1:0]; alu_hi[0] = sub_w[DATA_W]; end
            4'd4: alu_lo = y << shamt;
            4'd5: alu_lo = y >> shamt;
            4'd6: alu_lo = $signed(y) >>> shamt;
            4'd7: alu_lo = ~bus;
            4'd8: alu_lo = '0 - bus;
            default: alu_lo = '0;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide; both leave hi:lo as the Z image.
    logic [DATA_W:0]   mul_sum, div_sh;
    logic              div_ge;
    logic [DATA_W-1:0] div_df, step_hi, step_lo;
    logic              md_start, md_last;

    assign mul_sum = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : '0);
    assign div_sh  = {md_hi, md_lo[DATA_W-1]};
    assign div_ge  = (div_sh >= {1'b0, md_b});
    assign div_df  = div_sh[DATA_W-1:0] - md_b;
    assign step_hi = md_div ? (div_ge ? div_df : div_sh[DATA_W-1:0]) : mul_sum[DATA_W:1];
    assign step_lo = md_div ? {md_lo[DATA_W-2:0], div_ge} : {mul_sum[0], md_lo[DATA_W-1:1]};

    assign md_start = alu_start && !alu_busy && (alu_op == OP_MUL || alu_op == OP_DIV);
    assign md_last  = alu_busy && (md_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            pc <= '0; ir <= '0; y <= '0; z_hi <= '0; z_lo <= '0;
            hi <= '0; lo <= '0; mdr <= '0;
            md_hi <= '0; md_lo <= '0; md_b <= '0; md_div <= 1'b0; md_cnt <= '0;
            alu_busy <= 1'b0;
            alu_done <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_in[i]) regs[i] <= bus;
            end
`ifdef DP_R0_ZERO_EN
            regs[0] <= '0;
`endif
            if (pc_in)       pc <= bus;
            else if (inc_pc) pc <= pc + DATA_W'(1);
            if (ir_in)  ir  <= bus;
            if (y_in)   y   <= bus;
            if (hi_in)  hi  <= bus;
            if (lo_in)  lo  <= bus;
            if (mdr_in) mdr <= mdr_read ? mdatain : bus;

            alu_done <= 1'b0;
            if (alu_busy) begin
                md_hi  <= step_hi;
                md_lo  <= step_lo;
                md_cnt <= md_cnt + CNT_W'(1);
                if (md_last) begin
                    alu_busy <= 1'b0;
                    alu_done <= 1'b1;
                    z_hi     <= step_hi;
                    z_lo     <= step_lo;
                end
            end else begin
                if (z_in) begin
                    z_hi <= alu_hi;
                    z_lo <= alu_lo;
                end
                if (md_start) begin
                    alu_busy <= 1'b1;
                    md_cnt   <= '0;
                    md_div   <= (alu_op == OP_DIV);
                    md_hi    <= '0;
                    md_lo    <= (alu_op == OP_DIV) ? y : bus;
                    md_b     <= (alu_op == OP_DIV) ? bus : y;
                end
            end
        end
    end
endmodule

// File: tb/tb_bus_datapath_gen2.sv
// tb/tb_bus_datapath_gen2.sv - self-checking bench for bus_datapath_gen2
module tb_bus_datapath_gen2;
    localparam int W = 32;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          clr;
    logic [N-1:0]  reg_in, reg_out;
    logic          pc_in, ir_in, y_in, z_in, hi_in, lo_in, mdr_in;
    logic          pc_out, hi_out, lo_out, zhigh_out, zlow_out, mdr_out, inport_out;
    logic          inc_pc, mdr_read, alu_start;
    logic [3:0]    alu_op;
    logic [W-1:0]  mdatain, inport_data, bus, ir_q;
    logic          bus_conflict, alu_busy, alu_done;

    int n_chk = 0;
    int n_fail = 0;
    logic [W-1:0] m_zhi, m_zlo;
    logic [W-1:0] shadow [N];

    bus_datapath_gen2 dut (
        .clk(clk), .clr(clr), .reg_in(reg_in), .reg_out(reg_out),
        .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in),
        .lo_in(lo_in), .mdr_in(mdr_in), .pc_out(pc_out), .hi_out(hi_out),
        .lo_out(lo_out), .zhigh_out(zhigh_out), .zlow_out(zlow_out),
        .mdr_out(mdr_out), .inport_out(inport_out), .inc_pc(inc_pc),
        .mdr_read(mdr_read), .alu_op(alu_op), .alu_start(alu_start),
        .mdatain(mdatain), .inport_data(inport_data), .bus(bus), .ir_q(ir_q),
        .bus_conflict(bus_conflict), .alu_busy(alu_busy), .alu_done(alu_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b, lo, hi;
    } alu_vec_t;
    alu_vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 0; reg_in = '0; reg_out = '0;
        pc_in = 0; ir_in = 0; y_in = 0; z_in = 0; hi_in = 0; lo_in = 0; mdr_in = 0;
        pc_out = 0; hi_out = 0; lo_out = 0; zhigh_out = 0; zlow_out = 0; mdr_out = 0;
        inport_out = 0; inc_pc = 0; mdr_read = 0; alu_start = 0; alu_op = '0;
        mdatain = '0; inport_data = '0;
    endtask

    task automatic load_reg(input int i, input logic [W-1:0] v);
        idle(); inport_data = v; inport_out = 1; reg_in[i] = 1; tick(); idle();
    endtask

    task automatic set_y(input logic [W-1:0] v);
        idle(); inport_data = v; inport_out = 1; y_in = 1; tick(); idle();
    endtask

    task automatic peek_reg(input int i, output logic [W-1:0] v);
        idle(); reg_out[i] = 1; #1 v = bus; idle();
    endtask

    task automatic peek_z(output logic [W-1:0] h, output logic [W-1:0] l);
        idle(); zhigh_out = 1; #1 h = bus;
        idle(); zlow_out = 1;  #1 l = bus; idle();
    endtask

    task automatic peek_pc(output logic [W-1:0] v);
        idle(); pc_out = 1; #1 v = bus; idle();
    endtask

    // Reference ALU from the operation definitions, {Z_hi, Z_lo}.
    function automatic logic [63:0] model_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] r;
        case (op)
            4'd0: r = {32'd0, a & b};
            4'd1: r = {32'd0, a | b};
            4'd2: r = 64'(a) + 64'(b);
            4'd3: r = {31'd0, (a < b), a - b};
            4'd4: r = {32'd0, a << b[4:0]};
            4'd5: r = {32'd0, a >> b[4:0]};
            4'd6: r = {32'd0, 32'($signed(a) >>> b[4:0])};
            4'd7: r = {32'd0, ~b};
            4'd8: r = {32'd0, 32'd0 - b};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    task automatic alu1(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        set_y(a);
        inport_data = b; inport_out = 1; alu_op = op; z_in = 1; tick(); idle();
    endtask

    task automatic run_md(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        int n;
        logic [63:0] e;
        logic [W-1:0] h, l;
        set_y(a);
        inport_data = b; inport_out = 1; alu_op = op; alu_start = 1; tick(); idle();
        n = 0;
        while (alu_busy === 1'b1 && n < 100) begin
            if (poke && n == 3) begin
                inport_data = '1; inport_out = 1; alu_op = 4'd0; z_in = 1; alu_start = 1;
            end
            if (poke && n == 4) begin
                zlow_out = 1; #1 chk("z_hold_busy", bus, m_zlo);
            end
            n++;
            tick(); idle();
        end
        chk("md_busy_cycles", n, W);
        chk("md_done_pulse", alu_done, 1);
        if (op == 4'd9)      e = 64'(a) * 64'(b);
        else if (b == 0)     e = {a, 32'hFFFF_FFFF};
        else                 e = {a % b, a / b};
        m_zhi = e[63:32]; m_zlo = e[31:0];
        tick();
        chk("md_done_clear", alu_done, 0);
        peek_z(h, l);
        chk("md_zhi", h, m_zhi);
        chk("md_zlo", l, m_zlo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] v, h, l;
        logic [63:0]  e;
        bit seen;

        vecs[0]  = '{4'd2,  32'hFFFF_FFFF, 32'h1,         32'h0,         32'h1};
        vecs[1]  = '{4'd6,  32'h8000_0000, 32'h4,         32'hF800_0000, 32'h0};
        vecs[2]  = '{4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0};
        vecs[3]  = '{4'd1,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 32'h0};
        vecs[4]  = '{4'd3,  32'h5,         32'h7,         32'hFFFF_FFFE, 32'h1};
        vecs[5]  = '{4'd3,  32'h7,         32'h5,         32'h2,         32'h0};
        vecs[6]  = '{4'd4,  32'h1,         32'h3F,        32'h8000_0000, 32'h0};
        vecs[7]  = '{4'd5,  32'h8000_0000, 32'h4,         32'h0800_0000, 32'h0};
        vecs[8]  = '{4'd7,  32'h1234_5678, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0};
        vecs[9]  = '{4'd8,  32'h0,         32'h1,         32'hFFFF_FFFF, 32'h0};
        vecs[10] = '{4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0};
        vecs[11] = '{4'd9,  32'h7,         32'h6,         32'h0,         32'h0};

        idle(); clr = 1; tick(); tick(); idle();
        for (int i = 0; i < N; i++) shadow[i] = '0;
        m_zhi = '0; m_zlo = '0;

        #1;
        chk("rst_bus", bus, 0);
        chk("rst_conflict", bus_conflict, 0);
        chk("rst_busy", alu_busy, 0);
        chk("rst_done", alu_done, 0);
        chk("rst_ir", ir_q, 0);
        peek_pc(v); chk("rst_pc", v, 0);
        peek_reg(5, v); chk("rst_r5", v, 0);

        // MDR from memory, then onto the bus into R3
        mdr_read = 1; mdatain = 32'h12; mdr_in = 1; tick(); idle();
        mdr_out = 1; reg_in[3] = 1; #1;
        chk("mdr_bus", bus, 32'h12);
        chk("mdr_conflict", bus_conflict, 0);
        tick(); idle(); shadow[3] = 32'h12;
        peek_reg(3, v); chk("r3_from_mdr", v, 32'h12);

        for (int i = 0; i < 12; i++) begin
            alu1(vecs[i].op, vecs[i].a, vecs[i].b);
            m_zhi = vecs[i].hi; m_zlo = vecs[i].lo;
            peek_z(h, l);
            chk($sformatf("vec%0d_zhi", i), h, vecs[i].hi);
            chk($sformatf("vec%0d_zlo", i), l, vecs[i].lo);
        end

        // Multi-cycle: MUL 7*6 with a z_in poke during busy, DIV cases
        alu1(4'd1, 32'hABCD_0000, 32'h0000_1234);
        m_zhi = 0; m_zlo = 32'hABCD_1234;
        run_md(4'd9, 32'd7, 32'd6, 1);
        run_md(4'd10, 32'd100, 32'd7, 0);
        run_md(4'd10, 32'd5, 32'd0, 0);
        run_md(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        for (int k = 0; k < 4; k++)
            run_md((k % 2 == 0) ? 4'd9 : 4'd10, $urandom, (k == 3) ? 32'($urandom_range(1, 300)) : $urandom, 0);

        // Bus conflict and PC behaviour
        load_reg(1, 32'hDEAD_BEEF); shadow[1] = 32'hDEAD_BEEF;
        reg_out[1] = 1; pc_out = 1; #1;
        chk("conf_bus", bus, 0);
        chk("conf_flag", bus_conflict, 1);
        idle(); inport_data = 32'h40; inport_out = 1; pc_in = 1; inc_pc = 1; tick(); idle();
        peek_pc(v); chk("pc_in_wins", v, 32'h40);
        inc_pc = 1; tick(); idle();
        peek_pc(v); chk("pc_inc", v, 32'h41);
        inport_data = 32'hFFFF_FFFF; inport_out = 1; pc_in = 1; tick(); idle();
        inc_pc = 1; tick(); idle();
        peek_pc(v); chk("pc_wrap", v, 0);
        inport_data = 32'hCAFE_F00D; inport_out = 1; ir_in = 1; hi_in = 1; lo_in = 1; tick(); idle();
        chk("ir_q", ir_q, 32'hCAFE_F00D);
        hi_out = 1; #1 chk("hi_reg", bus, 32'hCAFE_F00D); idle();

        // Random ALU operations against the reference
        for (int k = 0; k < 40; k++) begin
            logic [3:0] op; logic [W-1:0] a, b;
            op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
            alu1(op, a, b);
            e = model_alu(op, a, b);
            m_zhi = e[63:32]; m_zlo = e[31:0];
            peek_z(h, l);
            chk($sformatf("rnd_alu_op%0d", op), {h, l}, e);
        end

        // Random register traffic against a shadow register file
        for (int k = 0; k < 20; k++) begin
            int d, s, d2; logic [W-1:0] rv;
            d = $urandom_range(1, N - 1); d2 = $urandom_range(1, N - 1); rv = $urandom;
            load_reg(d, rv); shadow[d] = rv;
            s = $urandom_range(1, N - 1);
            idle(); reg_out[s] = 1; reg_in[d2] = 1; tick(); idle(); shadow[d2] = shadow[s];
            peek_reg(d2, v); chk("rnd_copy", v, shadow[d2]);
        end

        // clr during busy cycle 10 of a MUL aborts it
        set_y(32'd7);
        inport_data = 32'd6; inport_out = 1; alu_op = 4'd9; alu_start = 1; tick(); idle();
        for (int k = 0; k < 9; k++) tick();
        chk("pre_clr_busy", alu_busy, 1);
        clr = 1; tick(); idle();
        chk("clr_busy", alu_busy, 0);
        chk("clr_done", alu_done, 0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (alu_done === 1'b1) seen = 1;
            tick();
        end
        chk("clr_no_done", seen, 0);
        peek_z(h, l);
        chk("clr_z", {h, l}, 0);

        // R0 behaviour depends on the build option
        load_reg(0, 32'h55);
        reg_out[0] = 1; #1;
`ifdef DP_R0_ZERO_EN
        chk("r0_zero", bus, 0);
`else
        chk("r0_normal", bus, 32'h55);
`endif
        chk("r0_conflict", bus_conflict, 0);
        pc_out = 1; #1;
        chk("r0_counts_driver", bus_conflict, 1);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
